// File: rtl/ascon_pkg.sv
// Shared Ascon accelerator types: 64-bit data word and AXI4-Stream TUSER payload.
package ascon_pkg;

  localparam int unsigned WORD_W = 64;

  typedef logic [WORD_W-1:0] ascon_word_t;

  typedef enum logic [1:0] {
    PKT_CT   = 2'd0,
    PKT_PT   = 2'd1,
    PKT_TAG  = 2'd2,
    PKT_HASH = 2'd3
  } pkt_class_e;

  typedef struct packed {
    pkt_class_e cls;
    logic [1:0] rsvd;
  } axi_tuser_t;

endpackage

// File: rtl/ascon_unpadder.sv
// Output-side AXI4-Stream formatter: drops alignment fillers, masks invalid bytes with
// the recorded TKEEP and places TLAST on the last real word of each packet.
module ascon_unpadder
  import ascon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ascon_word_t c_tdata,
  input  logic [7:0]  c_tkeep,
  input  axi_tuser_t  c_tuser,
  input  logic        c_tlast,
  input  logic        c_tdrop,
  input  logic        c_tvalid,
  output logic        c_tready,
  output ascon_word_t m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output axi_tuser_t  m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] byte_count_o,
  output logic        pkt_done_o,
  output logic        err_o
);

  localparam int unsigned KEEP_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned POP_W  = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FINAL = 2'd2
  } state_e;

  state_e state, state_nx;

  ascon_word_t       h_data;
  logic [KEEP_W-1:0] h_keep;
  axi_tuser_t        h_user;

  logic o_free;
  logic accept, real_acc, drop_acc;
  logic o_load, o_last_set;
  logic err_set;
  logic m_hs;
  logic restart;
  logic [POP_W-1:0] pop;
  logic [CNT_W:0]   sum;

  function automatic logic keep_ok(input logic [KEEP_W-1:0] k);
    logic ok;
    ok = 1'b0;
    case (k)
      8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic ascon_word_t mask_bytes(input ascon_word_t d, input logic [KEEP_W-1:0] k);
    ascon_word_t r;
    r = '0;
    for (int i = 0; i < int'(KEEP_W); i++) begin
      r[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
    end
    return r;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [KEEP_W-1:0] k);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(KEEP_W); i++) begin
      c = c + POP_W'(k[i]);
    end
    return c;
  endfunction

  assign o_free   = !m_axis_tvalid || m_axis_tready;
  assign accept   = c_tvalid && c_tready;
  assign real_acc = accept && !c_tdrop;
  assign drop_acc = accept && c_tdrop;
  assign m_hs     = m_axis_tvalid && m_axis_tready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_EMPTY;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_EMPTY: begin
        if (real_acc) state_nx = c_tlast ? ST_FINAL : ST_HOLD;
      end
      ST_HOLD: begin
        if (drop_acc)      state_nx = ST_EMPTY;
        else if (real_acc) state_nx = c_tlast ? ST_FINAL : ST_HOLD;
      end
      ST_FINAL: begin
        if (o_free) state_nx = ST_EMPTY;
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  // Upstream ready and H->O transfer control; ready is held low throughout reset
  always_comb begin
    c_tready   = 1'b0;
    o_load     = 1'b0;
    o_last_set = 1'b0;
    case (state)
      ST_EMPTY: c_tready = 1'b1;
      ST_HOLD: begin
        c_tready   = o_free;
        o_load     = c_tvalid && o_free;
        o_last_set = c_tdrop;
      end
      ST_FINAL: begin
        o_load     = o_free;
        o_last_set = 1'b1;
      end
      default: c_tready = 1'b0;
    endcase
    if (!rst) c_tready = 1'b0;
  end

  assign err_set = (real_acc && !keep_ok(c_tkeep))
                || (o_load && !o_last_set && (h_keep != 8'hFF))
                || (drop_acc && (state == ST_EMPTY))
                || (drop_acc && !c_tlast);

  // Hold register: the newest real word, waiting to learn whether it ends the packet
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_data <= '0;
      h_keep <= '0;
      h_user <= '0;
    end else if (real_acc) begin
      h_data <= c_tdata;
      h_keep <= c_tkeep;
      h_user <= c_tuser;
    end
  end

  // Output register; o_load only fires when O is free, so AXI stability holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (o_load) begin
      m_axis_tdata  <= mask_bytes(h_data, h_keep);
      m_axis_tkeep  <= h_keep;
      m_axis_tuser  <= h_user;
      m_axis_tlast  <= o_last_set;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  assign pop = popcount(m_axis_tkeep);
  assign sum = (CNT_W+1)'(byte_count_o) + (CNT_W+1)'(pop);

  // Per-packet byte counter; the first handshake after a tlast restarts it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_count_o <= '0;
      restart      <= 1'b1;
      pkt_done_o   <= 1'b0;
    end else begin
      pkt_done_o <= m_hs && m_axis_tlast;
      if (m_hs) begin
        if (restart)     byte_count_o <= CNT_W'(pop);
        else if (sum[CNT_W]) byte_count_o <= '1;
        else             byte_count_o <= sum[CNT_W-1:0];
        restart <= m_axis_tlast;
      end
    end
  end

  // Sticky protocol error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err_o <= 1'b0;
    else if (err_set) err_o <= 1'b1;
  end

endmodule

// File: tb/tb_ascon_unpadder.sv
// Directed bench for ascon_unpadder: table of input words with hand-computed outputs,
// plus hand-written backpressure, reset and error sequences.
module tb_ascon_unpadder;
  import ascon_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  ascon_word_t c_tdata;
  logic [7:0]  c_tkeep;
  axi_tuser_t  c_tuser;
  logic        c_tlast, c_tdrop, c_tvalid, c_tready;
  ascon_word_t m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  axi_tuser_t  m_axis_tuser;
  logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [15:0] byte_count_o;
  logic        pkt_done_o, err_o;

  ascon_unpadder dut (
    .clk(clk), .rst(rst),
    .c_tdata(c_tdata), .c_tkeep(c_tkeep), .c_tuser(c_tuser), .c_tlast(c_tlast),
    .c_tdrop(c_tdrop), .c_tvalid(c_tvalid), .c_tready(c_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .byte_count_o(byte_count_o), .pkt_done_o(pkt_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    ascon_word_t data;
    logic [7:0]  keep;
    axi_tuser_t  user;
    logic        last;
    logic        drop;
    logic        emit;
    ascon_word_t exp_data;
    logic        exp_last;
  } vec_t;

  typedef struct {
    ascon_word_t data;
    logic [7:0]  keep;
    axi_tuser_t  user;
    logic        last;
  } out_t;

  localparam axi_tuser_t U_CT   = '{cls: PKT_CT,   rsvd: 2'b00};
  localparam axi_tuser_t U_PT   = '{cls: PKT_PT,   rsvd: 2'b00};
  localparam axi_tuser_t U_TAG  = '{cls: PKT_TAG,  rsvd: 2'b00};
  localparam axi_tuser_t U_HASH = '{cls: PKT_HASH, rsvd: 2'b00};

  vec_t vecs[12];
  out_t out_q[$];
  int   bc_q[$];
  int   acc_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   pd_cnt = 0;
  int   cyc = 0;
  logic hs_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (hs_prev) bc_q.push_back(int'(byte_count_o));
    hs_prev = m_axis_tvalid && m_axis_tready && rst;
    if (hs_prev) out_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast});
    if (pkt_done_o) pd_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    out_q.delete();
    bc_q.delete();
    acc_q.delete();
    pd_cnt = 0;
  endtask

  task automatic send(input ascon_word_t d, input logic [7:0] k, input axi_tuser_t u,
                      input logic l, input logic dr);
    int n;
    c_tdata = d; c_tkeep = k; c_tuser = u; c_tlast = l; c_tdrop = dr; c_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!c_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!c_tready) begin
      chk("send_timeout", 64'(c_tready), 64'd1);
    end else begin
      @(posedge clk);
      #1;
      acc_q.push_back(cyc);
    end
    c_tvalid = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      send(vecs[i].data, vecs[i].keep, vecs[i].user, vecs[i].last, vecs[i].drop);
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (out_q.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("out_count", 64'(out_q.size()), 64'(n));
  endtask

  task automatic check_rows(input int lo, input int hi);
    int k;
    k = 0;
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].emit) begin
        if (k < out_q.size()) begin
          chk($sformatf("row%0d_data", i), out_q[k].data, vecs[i].exp_data);
          chk($sformatf("row%0d_keep", i), 64'(out_q[k].keep), 64'(vecs[i].keep));
          chk($sformatf("row%0d_user", i), 64'(out_q[k].user), 64'(vecs[i].user));
          chk($sformatf("row%0d_last", i), 64'(out_q[k].last), 64'(vecs[i].exp_last));
        end
        k++;
      end
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // PT packet: FF, FF, 03+last
    vecs[0]  = '{64'h1111_2222_3333_4444, 8'hFF, U_PT, 1'b0, 1'b0, 1'b1, 64'h1111_2222_3333_4444, 1'b0};
    vecs[1]  = '{64'h5555_6666_7777_8888, 8'hFF, U_PT, 1'b0, 1'b0, 1'b1, 64'h5555_6666_7777_8888, 1'b0};
    vecs[2]  = '{64'hAAAA_BBBB_CCCC_DDDD, 8'h03, U_PT, 1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_DDDD, 1'b1};
    // CT packet ending in an alignment filler
    vecs[3]  = '{64'h0123_4567_89AB_CDEF, 8'hFF, U_CT, 1'b0, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[4]  = '{64'hFEDC_BA98_7654_3210, 8'h0F, U_CT, 1'b0, 1'b0, 1'b1, 64'h0000_0000_7654_3210, 1'b1};
    vecs[5]  = '{64'hDEAD_BEEF_DEAD_BEEF, 8'h00, U_CT, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0};
    // Hash digest then tag, back to back
    vecs[6]  = '{64'h4841_5348_0000_0001, 8'hFF, U_HASH, 1'b0, 1'b0, 1'b1, 64'h4841_5348_0000_0001, 1'b0};
    vecs[7]  = '{64'h4841_5348_0000_0002, 8'hFF, U_HASH, 1'b0, 1'b0, 1'b1, 64'h4841_5348_0000_0002, 1'b0};
    vecs[8]  = '{64'h4841_5348_0000_0003, 8'hFF, U_HASH, 1'b0, 1'b0, 1'b1, 64'h4841_5348_0000_0003, 1'b0};
    vecs[9]  = '{64'h4841_5348_0000_0004, 8'hFF, U_HASH, 1'b1, 1'b0, 1'b1, 64'h4841_5348_0000_0004, 1'b1};
    vecs[10] = '{64'h5441_4700_0000_00A1, 8'hFF, U_TAG, 1'b0, 1'b0, 1'b1, 64'h5441_4700_0000_00A1, 1'b0};
    vecs[11] = '{64'h5441_4700_0000_00A2, 8'hFF, U_TAG, 1'b1, 1'b0, 1'b1, 64'h5441_4700_0000_00A2, 1'b1};

    rst = 1'b0;
    c_tdata = '0; c_tkeep = '0; c_tuser = '0; c_tlast = 1'b0; c_tdrop = 1'b0; c_tvalid = 1'b0;
    m_axis_tready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_c_tready", 64'(c_tready), 64'd0);
    chk("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_byte_count", 64'(byte_count_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_pkt_done", 64'(pkt_done_o), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_c_tready", 64'(c_tready), 64'd1);

    // PT packet
    sync();
    clear_obs();
    run_rows(0, 2);
    wait_out(3);
    check_rows(0, 2);
    chk("pt_byte_count", 64'(byte_count_o), 64'd18);
    chk("pt_pkt_done", 64'(pd_cnt), 64'd1);
    chk("pt_err", 64'(err_o), 64'd0);

    // CT packet ending with a drop word: no input bubble
    sync();
    clear_obs();
    run_rows(3, 5);
    wait_out(2);
    check_rows(3, 5);
    chk("ct_byte_count", 64'(byte_count_o), 64'd12);
    chk("ct_no_bubble", 64'(acc_q[2] - acc_q[0]), 64'd2);
    chk("ct_pkt_done", 64'(pd_cnt), 64'd1);
    chk("ct_err", 64'(err_o), 64'd0);

    // Backpressure: 8-word packet, m_axis_tready low for 5 cycles after the third output
    sync();
    clear_obs();
    fork
      begin
        for (int i = 1; i <= 8; i++)
          send(64'hC0DE_0000_0000_0000 | 64'(i), 8'hFF, U_PT, (i == 8), 1'b0);
      end
      begin
        int t;
        t = 0;
        while (out_q.size() < 3 && t < 200) begin
          @(negedge clk);
          t++;
        end
        sync();
        m_axis_tready = 1'b0;
        @(negedge clk);
        chk("bp_ready_drop", 64'(c_tready), 64'd0);
        repeat (4) @(negedge clk);
        sync();
        m_axis_tready = 1'b1;
      end
    join
    wait_out(8);
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      chk($sformatf("bp_data%0d", i), out_q[i].data, 64'hC0DE_0000_0000_0000 | 64'(i + 1));
      chk($sformatf("bp_last%0d", i), 64'(out_q[i].last), 64'(i == 7));
    end
    chk("bp_byte_count", 64'(byte_count_o), 64'd64);

    // Hash digest then tag back to back: one bubble per packet, counter restarts
    sync();
    clear_obs();
    run_rows(6, 11);
    wait_out(6);
    check_rows(6, 11);
    chk("ht_one_bubble", 64'(acc_q[5] - acc_q[0]), 64'd6);
    if (bc_q.size() >= 6) begin
      chk("ht_bc_first", 64'(bc_q[0]), 64'd8);
      chk("ht_bc_hash", 64'(bc_q[3]), 64'd32);
      chk("ht_bc_restart", 64'(bc_q[4]), 64'd8);
    end else begin
      chk("ht_bc_samples", 64'(bc_q.size()), 64'd6);
    end
    chk("ht_byte_count", 64'(byte_count_o), 64'd16);
    chk("ht_pkt_done", 64'(pd_cnt), 64'd2);
    chk("ht_err", 64'(err_o), 64'd0);

    // Illegal keep on the last word: sticky error, bytes still masked
    sync();
    clear_obs();
    send(64'h1122_3344_5566_7788, 8'h05, U_CT, 1'b1, 1'b0);
    wait_out(1);
    if (out_q.size() > 0) begin
      chk("k05_data", out_q[0].data, 64'h0000_0000_0066_0088);
      chk("k05_last", 64'(out_q[0].last), 64'd1);
    end
    chk("k05_err", 64'(err_o), 64'd1);
    repeat (5) @(negedge clk);
    chk("k05_err_sticky", 64'(err_o), 64'd1);

    // Mid-packet reset with a word held in O
    sync();
    clear_obs();
    m_axis_tready = 1'b0;
    send(64'h0000_0000_0000_0001, 8'hFF, U_CT, 1'b0, 1'b0);
    send(64'h0000_0000_0000_0002, 8'hFF, U_CT, 1'b0, 1'b0);
    #2;
    chk("mid_pre_valid", 64'(m_axis_tvalid), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_data", m_axis_tdata, 64'd0);
    chk("mid_rst_c_tready", 64'(c_tready), 64'd0);
    chk("mid_rst_err", 64'(err_o), 64'd0);
    chk("mid_rst_byte_count", 64'(byte_count_o), 64'd0);
    sync();
    rst = 1'b1;
    m_axis_tready = 1'b1;
    clear_obs();
    @(negedge clk);
    chk("mid_post_c_tready", 64'(c_tready), 64'd1);
    sync();
    run_rows(10, 11);
    wait_out(2);
    check_rows(10, 11);
    chk("tag_byte_count", 64'(byte_count_o), 64'd16);
    chk("tag_err", 64'(err_o), 64'd0);

    // Drop word while empty: flagged, consumed, nothing emitted
    sync();
    clear_obs();
    send(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, U_CT, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    chk("drop_empty_err", 64'(err_o), 64'd1);
    chk("drop_empty_out", 64'(out_q.size()), 64'd0);
    chk("drop_empty_valid", 64'(m_axis_tvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ascon_unpadder.md
# ascon_unpadder

Output-side AXI4-Stream formatter for the Ascon accelerator. It sits between the core/FSM output mux and the external master port, which makes it the inverse of the input padding stage. It discards rate-alignment filler words, zeroes and masks invalid trailing bytes with the recorded TKEEP, and asserts TLAST on the last real word. Packets covered: ciphertext, plaintext, tag and hash digest.

## Interface
- No parameters. Word width is `ascon_word_t` (64 b); `axi_tuser_t` comes from `ascon_pkg`.
- `clk`  in  1  sole clock; all registers rise-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `c_tdata`  in  64  core output word; byte 0 = bits [7:0].
- `c_tkeep`  in  8  valid bytes of this word (recorded from the input side); ignored when `c_tdrop=1`.
- `c_tuser`  in  `axi_tuser_t`  packet class; passed through.
- `c_tlast`  in  1  last core word of the packet, filler included.
- `c_tdrop`  in  1  word is an alignment filler; it is consumed and never emitted.
- `c_tvalid` in 1; `c_tready` out 1  upstream handshake.
- `m_axis_tdata` out 64; `m_axis_tkeep` out 8; `m_axis_tuser` out `axi_tuser_t`; `m_axis_tlast` out 1; `m_axis_tvalid` out 1; `m_axis_tready` in 1  external master stream.
- `byte_count_o`  out  16  bytes emitted in the current or most recent packet; saturates at 16'hFFFF.
- `pkt_done_o`  out  1  one-cycle pulse after the handshake of the tlast word.
- `err_o`  out  1  sticky protocol error flag; cleared only by reset.

## Operation
- Storage: hold register H (data, keep, user, final flag) plus output register O, which drives the `m_axis_*` outputs. An upstream word is accepted when `c_tvalid && c_tready`.
- Why H exists: a real word cannot be emitted until the block knows whether its successor is a filler, because that decides the word's tlast.
- Define O_free = !O_valid || m_axis_tready.
- FSM states, always `c_tready` gating:
  - ST_EMPTY: `c_tready=1`.
    - real word, !last → load H, go to ST_HOLD.
    - real word, last → load H, go to ST_FINAL.
    - drop word → err, discard, stay in ST_EMPTY.
  - ST_HOLD: `c_tready=O_free`.
    - real word, !last → H to O with tlast=0, new word to H, stay in ST_HOLD.
    - real word, last → H to O with tlast=0, new word to H, go to ST_FINAL.
    - drop word → H to O with tlast=1, go to ST_EMPTY. If the drop word lacks `c_tlast`, set err and still treat it as last.
  - ST_FINAL: `c_tready=0`. When O_free, H to O with tlast=1, go to ST_EMPTY.
- On every load of O:
  - `m_axis_tkeep` = H.keep.
  - Data bytes whose keep bit is 0 are forced to 8'h00.
  - `tuser` passes through unmodified.
- Error conditions (set `err_o`; data flow continues unchanged):
  - real word with keep not in {01,03,07,0F,1F,3F,7F,FF};
  - H moved to O with tlast=0 while H.keep≠FF;
  - drop word in ST_EMPTY;
  - drop word without `c_tlast`.
- Byte counter:
  - On each m handshake, `byte_count_o` += popcount(tkeep), saturating.
  - The first handshake after a tlast handshake loads popcount instead of accumulating.
  - On the tlast handshake, `pkt_done_o` pulses high the next cycle and `byte_count_o` then holds the final value.

## Timing
- Reset, asserted asynchronously:
  - all outputs go to 0, including `c_tready`; `c_tready` is forced 0 while `rst` is low;
  - state goes to ST_EMPTY, H and O are cleared, the counter is cleared, and `err_o` is cleared.
  - The first cycle after release has `c_tready=1`.
  - A mid-packet reset drops the packet silently.
- Latency:
  - a non-final word reaches O on the edge that accepts its successor;
  - a final real word is accepted at edge k and becomes valid on `m_axis` after edge k+1 if O_free was true in cycle k.
- ST_FINAL inserts exactly one input bubble per packet that ends on a real word. No bubble occurs when the packet ends with a drop word.
- O obeys AXI rules: once valid, its data, keep, user and last are stable until `m_axis_tready`.
- Simultaneous events: when O drains and reloads on the same edge, no bubble occurs. Sustained throughput is 1 word/cycle inside a packet.

## Test plan
- PT packet keeps FF,FF,03, third with last → 3 outputs, third tkeep=03, tdata[63:16]=0, tlast only on third, byte_count_o=18, pkt_done_o pulses once, err_o=0.
- AEAD alignment: CT keeps FF then 0F, then drop+last → 2 outputs, second tlast=1 tkeep=0F, filler not emitted, byte_count_o=12.
- Backpressure: 8-word packet, `m_axis_tready` low for 5 cycles after word 3 → `c_tready` drops within 1 cycle, output sequence identical with no loss or duplication, tlast on word 8.
- Errors: keep=05 on the last word → err_o=1 and stays 1. Drop word in ST_EMPTY → err_o=1 and nothing emitted.
- Reset pulse (rst=0 for 1 cycle) mid-packet → all outputs 0 immediately. A following 2-word tag packet (keeps FF,FF) emits correctly with byte_count_o=16.
- Back-to-back hash digest (4×FF, last) then tag (2×FF, last) → tlast on outputs 4 and 6, one bubble per packet, byte_count_o restarts at 8 on the tag's first handshake.
